// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - RV32M issue sequencer between ID/EX and the M unit
// Holds one instruction at the M unit inputs, short-circuits div-by-zero/overflow, returns one write-back beat.
module muldiv_issue_ctrl #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  OP_WIDTH   = 5,
  parameter int                  SIMD_WIDTH = 2,
  parameter logic [OP_WIDTH-1:0] NOP_OP     = '0,
  parameter int                  TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [OP_WIDTH-1:0]   ex_aluop,
  input  logic [2:0]            ex_funct3,
  input  logic [DATA_WIDTH-1:0] ex_s1,
  input  logic [DATA_WIDTH-1:0] ex_s2,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_simd_ena,
  input  logic [SIMD_WIDTH-1:0] ex_simd_ctl,
  input  logic                  flush,
  input  logic                  div_ready,
  input  logic [DATA_WIDTH-1:0] m_data,
  output logic [OP_WIDTH-1:0]   m_aluop,
  output logic [DATA_WIDTH-1:0] m_s1,
  output logic [DATA_WIDTH-1:0] m_s2,
  output logic                  m_simd_ena,
  output logic [SIMD_WIDTH-1:0] m_simd_ctl,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV_ARM, DIV_WAIT, DRAIN} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  fast_q;
  logic [DATA_WIDTH-1:0] fast_val_q;

  logic                  is_div;
  logic                  is_rem;
  logic                  is_signed;
  logic                  s2_zero;
  logic                  ovf;
  logic                  fast_hit;
  logic [DATA_WIDTH-1:0] fast_val;
  logic                  cnt_last;

  assign stall    = (state != IDLE);
  assign cnt_last = (cnt == CW'(TIMEOUT - 2));

  // Divide corner cases resolved at accept so the divider is never started for them.
  always_comb begin
    is_div    = ex_funct3[2];
    is_rem    = ex_funct3[1];
    is_signed = ~ex_funct3[0];
    s2_zero   = (ex_s2 == '0);
    ovf       = is_signed && (ex_s1 == INT_MIN) && (ex_s2 == '1);
    fast_hit  = !ex_simd_ena && is_div && (s2_zero || ovf);
    fast_val  = '0;
    if (s2_zero)
      fast_val = is_rem ? ex_s1 : '1;
    else
      fast_val = is_rem ? '0 : INT_MIN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fast_q     <= 1'b0;
      fast_val_q <= '0;
      m_aluop    <= NOP_OP;
      m_s1       <= '0;
      m_s2       <= '0;
      m_simd_ena <= 1'b0;
      m_simd_ctl <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      err        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && !flush) begin
            m_aluop    <= fast_hit ? NOP_OP : ex_aluop;
            m_s1       <= ex_s1;
            m_s2       <= ex_s2;
            m_simd_ena <= ex_simd_ena;
            m_simd_ctl <= ex_simd_ctl;
            wb_rd      <= ex_rd;
            fast_q     <= fast_hit;
            fast_val_q <= fast_val;
            state      <= (fast_hit || !is_div) ? MUL : DIV_ARM;
          end
        end
        MUL: begin
          m_aluop <= NOP_OP;
          state   <= IDLE;
          if (!flush) begin
            wb_valid <= 1'b1;
            wb_data  <= fast_q ? fast_val_q : m_data;
          end
        end
        DIV_ARM: begin
          // A ready left over from a previous divide may still be high here.
          cnt <= '0;
          if (flush) begin
            m_aluop <= NOP_OP;
            state   <= DRAIN;
          end else begin
            state <= DIV_WAIT;
          end
        end
        DIV_WAIT: begin
          if (flush) begin
            m_aluop <= NOP_OP;
            cnt     <= cnt + 1'b1;
            state   <= div_ready ? IDLE : DRAIN;
          end else if (div_ready) begin
            m_aluop  <= NOP_OP;
            wb_valid <= 1'b1;
            wb_data  <= m_data;
            state    <= IDLE;
          end else if (cnt_last) begin
            m_aluop <= NOP_OP;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (div_ready || cnt_last)
            state <= IDLE;
          else
            cnt <= cnt + 1'b1;
        end
        default: begin
          m_aluop <= NOP_OP;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb/tb_muldiv_issue_ctrl.sv - directed self-checking bench for muldiv_issue_ctrl
module tb_muldiv_issue_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_aluop;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_s1, ex_s2;
  logic [4:0]  ex_rd;
  logic        ex_simd_ena;
  logic [1:0]  ex_simd_ctl;
  logic        flush;
  logic        div_ready;
  logic [31:0] m_data;
  logic [4:0]  m_aluop;
  logic [31:0] m_s1, m_s2;
  logic        m_simd_ena;
  logic [1:0]  m_simd_ctl;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int wb_total    = 0;
  int back2back   = 0;
  logic wb_prev   = 1'b0;

  muldiv_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_funct3(ex_funct3),
    .ex_s1(ex_s1), .ex_s2(ex_s2), .ex_rd(ex_rd), .ex_simd_ena(ex_simd_ena),
    .ex_simd_ctl(ex_simd_ctl), .flush(flush), .div_ready(div_ready), .m_data(m_data),
    .m_aluop(m_aluop), .m_s1(m_s1), .m_s2(m_s2), .m_simd_ena(m_simd_ena),
    .m_simd_ctl(m_simd_ctl), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_valid) wb_total++;
    if (wb_valid && wb_prev) back2back++;
    wb_prev = wb_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] rd, input logic [4:0] op);
    ex_valid  = 1'b1;
    ex_funct3 = f3;
    ex_s1     = s1;
    ex_s2     = s2;
    ex_rd     = rd;
    ex_aluop  = op;
  endtask

  // Divide with ready modelled 10 cycles after accept plus a stale ready in DIV_ARM.
  task automatic div_run(input string tag, input logic [2:0] f3, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] result);
    int sc;
    int early;
    sc    = 0;
    early = 0;
    issue(f3, s1, s2, 5'd4, 5'd9);
    step();
    ex_valid = 1'b0;
    chk({tag, "_aluop"}, m_aluop, 5'd9);
    for (int k = 1; k <= 10; k++) begin
      if (stall) sc++;
      if (wb_valid) early++;
      div_ready = (k == 1) || (k == 10);
      m_data    = (k == 10) ? result : 32'h0000BAD0;
      step();
    end
    div_ready = 1'b0;
    chk({tag, "_stall_cycles"}, sc, 10);
    chk({tag, "_early_wb"}, early, 0);
    chk({tag, "_wb_valid"}, wb_valid, 1'b1);
    chk({tag, "_wb_data"}, wb_data, result);
    chk({tag, "_stall_after"}, stall, 1'b0);
    step();
  endtask

  task automatic fast(input string tag, input logic [2:0] f3, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] result);
    issue(f3, s1, s2, 5'd5, 5'd9);
    m_data = 32'hDEADBEEF;
    step();
    ex_valid = 1'b0;
    chk({tag, "_no_div_start"}, m_aluop, 5'd0);
    chk({tag, "_stall"}, stall, 1'b1);
    step();
    chk({tag, "_wb_valid"}, wb_valid, 1'b1);
    chk({tag, "_wb_data"}, wb_data, result);
  endtask

  initial begin
    int err_cnt;
    int err_k;
    int wb_k;
    rst = 1'b1; ex_valid = 1'b0; ex_aluop = '0; ex_funct3 = '0; ex_s1 = '0; ex_s2 = '0;
    ex_rd = '0; ex_simd_ena = 1'b0; ex_simd_ctl = '0; flush = 1'b0; div_ready = 1'b0; m_data = '0;
    step();
    step();
    chk("rst_m_aluop", m_aluop, 5'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m_s1", m_s1, 32'd0);
    rst = 1'b0;
    step();

    // MUL 7*6
    issue(3'd0, 32'd7, 32'd6, 5'd3, 5'd3);
    step();
    ex_valid = 1'b0;
    chk("mul_stall_t1", stall, 1'b1);
    chk("mul_aluop_t1", m_aluop, 5'd3);
    chk("mul_s1_t1", m_s1, 32'd7);
    chk("mul_s2_t1", m_s2, 32'd6);
    m_data = 32'd42;
    step();
    chk("mul_wb_valid_t2", wb_valid, 1'b1);
    chk("mul_wb_data", wb_data, 32'd42);
    chk("mul_wb_rd", wb_rd, 5'd3);
    chk("mul_stall_t2", stall, 1'b0);
    chk("mul_aluop_t2", m_aluop, 5'd0);
    step();
    chk("mul_wb_pulse", wb_valid, 1'b0);

    div_run("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    div_run("remu", 3'd7, 32'd100, 32'd7, 32'd2);

    fast("div_by0", 3'd4, 32'd123, 32'd0, 32'hFFFFFFFF);
    fast("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);
    fast("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    fast("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    step();

    // Flush of a divide at T+3; the next DIV waits in ID/EX until the drain ends.
    issue(3'd4, 32'd50, 32'd5, 5'd6, 5'd9);
    step();
    issue(3'd4, 32'd60, 32'd6, 5'd7, 5'd10);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_drain_stall_t4", stall, 1'b1);
    chk("flush_drain_aluop", m_aluop, 5'd0);
    step();
    chk("flush_drain_stall_t5", stall, 1'b1);
    div_ready = 1'b1;
    m_data    = 32'h00001234;
    step();
    div_ready = 1'b0;
    chk("flush_idle_t6", stall, 1'b0);
    chk("flush_killed_no_wb", wb_valid, 1'b0);
    step();
    ex_valid = 1'b0;
    chk("flush_next_accepted", stall, 1'b1);
    chk("flush_next_s1", m_s1, 32'd60);
    chk("flush_next_aluop", m_aluop, 5'd10);
    step();
    div_ready = 1'b1;
    m_data    = 32'd10;
    step();
    div_ready = 1'b0;
    chk("flush_next_wb_valid", wb_valid, 1'b1);
    chk("flush_next_wb_data", wb_data, 32'd10);
    chk("flush_next_wb_rd", wb_rd, 5'd7);
    step();

    // Divider never responds.
    err_cnt = 0;
    err_k   = -1;
    wb_k    = 0;
    issue(3'd4, 32'd10, 32'd3, 5'd8, 5'd9);
    step();
    ex_valid = 1'b0;
    for (int k = 1; k <= TIMEOUT + 3; k++) begin
      if (err) begin
        err_cnt++;
        err_k = k;
      end
      if (wb_valid) wb_k++;
      step();
    end
    chk("timeout_err_count", err_cnt, 1);
    chk("timeout_err_cycle", err_k, TIMEOUT + 1);
    chk("timeout_no_wb", wb_k, 0);
    chk("timeout_idle", stall, 1'b0);

    // Reset in the middle of DIV_WAIT.
    issue(3'd5, 32'd77, 32'd7, 5'd9, 5'd9);
    step();
    ex_valid = 1'b0;
    step();
    step();
    chk("rstmid_waiting", stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_stall", stall, 1'b0);
    chk("rstmid_aluop", m_aluop, 5'd0);
    chk("rstmid_s1", m_s1, 32'd0);
    chk("rstmid_wb_data", wb_data, 32'd0);
    chk("rstmid_wb_rd", wb_rd, 5'd0);
    step();
    rst = 1'b0;
    div_ready = 1'b1;
    m_data    = 32'd11;
    step();
    div_ready = 1'b0;
    chk("rstmid_no_wb_a", wb_valid, 1'b0);
    step();
    chk("rstmid_no_wb_b", wb_valid, 1'b0);

    chk("wb_total", wb_total, 8);
    chk("wb_back2back", back2back, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
